// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the iterative RV32M multiplier.
package mul_pkg;
  localparam int XLEN_C = 32;
  typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;
endpackage

// File: rtl/mul_shift_add_core.sv
// mul_shift_add_core: shift-add datapath holding the magnitude operands and the 64b accumulator.
module mul_shift_add_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [XLEN-1:0]   mcand_in,
  input  logic [XLEN-1:0]   mplier_in,
  output logic [2*XLEN-1:0] acc
);
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN:0]   sum;
  // carry out of the upper-half add is shifted back in as the new msb
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (mcand[0] ? {1'b0, mplier} : '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
    end else if (step) begin
      acc   <= {sum, acc[XLEN-1:1]};
      mcand <= mcand >> 1;
    end
endmodule

// File: rtl/mul_unit.sv
// mul_unit: iterative RV32M multiplier in EX, stalls the pipeline until the product is ready.
// Optional MUL_EARLY_OUT_EN: a zero operand skips the iterations and finishes in one stall cycle.
module mul_unit
  import mul_pkg::*;
#(
  parameter int XLEN  = XLEN_C,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_start,
  input  logic [1:0]      mul_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            mul_stall,
  output logic            mul_done,
  output logic [XLEN-1:0] mul_result
);
  mul_state_e      state;
  mul_op_e         op_in;
  mul_op_e         op_q;
  logic [CNT_W-1:0] cnt;
  logic            neg_q;
  logic            s1;
  logic            s2;
  logic            load;
  logic            step;
  logic            early_out;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] held;
  logic [XLEN-1:0] sel;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod;
  assign op_in = mul_op_e'(mul_op);
  assign s1    = rs1_data[XLEN-1] & (op_in != MULHU);
  assign s2    = rs2_data[XLEN-1] & (op_in == MUL || op_in == MULH);
  assign mag1  = s1 ? -rs1_data : rs1_data;
  assign mag2  = s2 ? -rs2_data : rs2_data;
`ifdef MUL_EARLY_OUT_EN
  assign early_out = (rs1_data == '0) || (rs2_data == '0);
`else
  assign early_out = 1'b0;
`endif
  assign load = (state == IDLE) && mul_start;
  assign step = state == BUSY;
  assign prod = neg_q ? -acc : acc;
  assign sel  = (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign mul_stall  = !rst && (load || step);
  assign mul_done   = state == DONE;
  assign mul_result = mul_done ? sel : held;
  mul_shift_add_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .mcand_in  (mag1),
    .mplier_in (mag2),
    .acc       (acc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= MUL;
      neg_q <= 1'b0;
      held  <= '0;
    end else begin
      state <= (state == IDLE) ? (mul_start ? (early_out ? DONE : BUSY) : IDLE) :
               (state == BUSY) ? ((cnt == CNT_W'(XLEN-1)) ? DONE : BUSY) : IDLE;
      cnt   <= step ? cnt + 1'b1 : '0;
      if (load) begin
        op_q  <= op_in;
        neg_q <= s1 ^ s2;
      end
      if (state == DONE) held <= sel;
    end
endmodule
